// File: rtl/ir_hit_decoder.sv
// ir_hit_decoder: pulse-width IR frame decoder exposing shooter ID through an APB3 slave.
module ir_hit_decoder #(
    parameter int TICK_DIV = 4000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        hit_data,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] PRDATA,
    output logic        FABINT
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, START_MARK, SPACE, BIT_MARK} state_t;
    state_t state, state_n;
    logic s1, s2, s3;
    logic [PW-1:0] pre;
    logic [7:0] dur, dur_now, shift, data;
    logic [2:0] bit_cnt;
    logic valid, overrun, error, enable, irq_en;
    logic fall, rise, tick, bit_ok, bit_val, done, err_set;
    logic wr, rd, clr;
    logic [1:0] addr;
    logic [31:0] rd_mux;
    logic unused;
    assign unused = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:3]};
    assign addr = PADDR[3:2];
    assign wr = PSEL & PENABLE & PWRITE;
    assign rd = PSEL & PENABLE & ~PWRITE;
    assign clr = wr && addr == 2'd3;
    // hit_data is active-low: a falling synchronized edge begins a mark
    assign fall = s3 & ~s2;
    assign rise = ~s3 & s2;
    assign tick = pre == PW'(TICK_DIV - 1);
    // duration including the current cycle, so a level of k cycles reads floor(k/TICK_DIV)
    assign dur_now = (tick && dur != 8'hff) ? dur + 8'd1 : dur;
    assign bit_val = dur_now >= 8'd9;
    always_comb begin
        state_n = state;
        bit_ok = 1'b0;
        done = 1'b0;
        err_set = 1'b0;
        if (!enable) state_n = IDLE;
        else case (state)
            IDLE: state_n = fall ? START_MARK : IDLE;
            START_MARK: begin
                if (rise) state_n = (dur_now >= 8'd18 && dur_now <= 8'd30) ? SPACE : IDLE;
                else if (dur_now >= 8'd31) state_n = IDLE;
            end
            SPACE: begin
                if (fall) begin
                    err_set = !(dur_now >= 8'd3 && dur_now <= 8'd15);
                    state_n = err_set ? IDLE : BIT_MARK;
                end else if (dur_now >= 8'd16) begin
                    err_set = 1'b1;
                    state_n = IDLE;
                end
            end
            BIT_MARK: begin
                if (rise) begin
                    bit_ok = dur_now >= 8'd3 && dur_now <= 8'd15;
                    err_set = !bit_ok;
                    done = bit_ok && bit_cnt == 3'd7;
                    state_n = (bit_ok && !done) ? SPACE : IDLE;
                end else if (dur_now >= 8'd31) begin
                    err_set = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            {s1, s2, s3} <= 3'b111;
            state <= IDLE;
            pre <= '0;
            dur <= '0;
            bit_cnt <= '0;
            shift <= '0;
            data <= '0;
            {valid, overrun, error, enable, irq_en} <= '0;
        end else begin
            {s1, s2, s3} <= {hit_data, s1, s2};
            state <= state_n;
            pre <= (!enable || fall || rise || tick) ? '0 : pre + 1'b1;
            dur <= (!enable || fall || rise) ? '0 : dur_now;
            bit_cnt <= state == START_MARK ? 3'd0 : bit_ok ? bit_cnt + 3'd1 : bit_cnt;
            shift <= bit_ok ? {shift[6:0], bit_val} : shift;
            data <= done ? {shift[6:0], bit_val} : data;
            valid <= done | (valid & ~(rd && addr == 2'd1) & ~(clr & PWDATA[0]));
            overrun <= (done & valid) | (overrun & ~(clr & PWDATA[1]));
            error <= err_set | (error & ~(clr & PWDATA[2]));
            {irq_en, enable} <= (wr && addr == 2'd2) ? PWDATA[1:0] : {irq_en, enable};
        end
    end
    assign rd_mux = addr == 2'd0 ? {28'd0, state != IDLE, error, overrun, valid} :
                    addr == 2'd1 ? {24'd0, data} :
                    addr == 2'd2 ? {30'd0, irq_en, enable} : 32'd0;
    assign PRDATA = (PSEL & ~PWRITE) ? rd_mux : 32'd0;
    assign FABINT = irq_en & valid;
    assign PREADY = 1'b1;
    assign PSLVERR = 1'b0;
endmodule

// File: tb/tb_ir_hit_decoder.sv
// tb_ir_hit_decoder: scoreboard bench for the IR hit decoder, one task per scenario.
module tb_ir_hit_decoder;
    localparam int TD = 4;
    logic clk = 1'b0;
    logic rst_n, psel, penable, pwrite, hit_data, pready, pslverr, fabint;
    logic [31:0] paddr, pwdata, prdata;
    logic [31:0] r, e;
    logic [31:0] exp_q[$];
    int passed = 0;
    int total = 0;

    ir_hit_decoder #(.TICK_DIV(TD)) dut (
        .PCLK(clk), .PRESERN(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .hit_data(hit_data), .PREADY(pready),
        .PSLVERR(pslverr), .PRDATA(prdata), .FABINT(fabint)
    );

    always #5 clk = ~clk;

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1;
        @(negedge clk);
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(negedge clk);
        penable = 1;
        d = prdata;
        @(negedge clk);
        psel = 0; penable = 0;
    endtask

    task automatic lvl(input logic v, input int t);
        hit_data = v;
        repeat (t * TD) @(negedge clk);
    endtask

    // leaves the final rising edge driven at the current negedge; caller handles latency
    task automatic send_frame(input logic [7:0] id, input int st, input int sp_a, input int sp_b,
                              input int m0, input int m1, input bit good);
        lvl(0, st);
        for (int i = 7; i >= 0; i--) begin
            lvl(1, (i % 2) ? sp_a : sp_b);
            lvl(0, id[i] ? m1 : m0);
        end
        hit_data = 1;
        if (good) exp_q.push_back({24'd0, id});
    endtask

    // most recent completion wins; older entries were overwritten in DATA
    task automatic pop_exp(output logic [31:0] v);
        v = exp_q.size() == 0 ? 32'hxxxx_xxxx : exp_q[$];
        exp_q.delete();
    endtask

    task automatic test_reset;
        total++; if (pready !== 1'b1) $display("FAIL reset_pready: got %b want 1", pready); else passed++;
        total++; if (pslverr !== 1'b0) $display("FAIL reset_pslverr: got %b want 0", pslverr); else passed++;
        total++; if (fabint !== 1'b0) $display("FAIL reset_fabint: got %b want 0", fabint); else passed++;
        total++; if (prdata !== 32'd0) $display("FAIL reset_prdata_idle: got %h want 0", prdata); else passed++;
        apb_read(0, r);
        total++; if (r !== 32'd0) $display("FAIL reset_status: got %h want 0", r); else passed++;
        apb_read(4, r);
        total++; if (r !== 32'd0) $display("FAIL reset_data: got %h want 0", r); else passed++;
        apb_read(8, r);
        total++; if (r !== 32'd0) $display("FAIL reset_ctrl: got %h want 0", r); else passed++;
    endtask

    task automatic test_basic;
        apb_write(8, 32'h3);
        apb_read(8, r);
        total++; if (r !== 32'h3) $display("FAIL ctrl_rw: got %h want 3", r); else passed++;
        send_frame(8'hA5, 24, 6, 6, 6, 12, 1);
        repeat (2) @(negedge clk);
        total++; if (fabint !== 1'b0) $display("FAIL latency_early: got %b want 0", fabint); else passed++;
        @(negedge clk);
        total++; if (fabint !== 1'b1) $display("FAIL latency_fabint: got %b want 1", fabint); else passed++;
        apb_read(0, r);
        total++; if (r !== 32'h1) $display("FAIL basic_status: got %h want 1", r); else passed++;
        apb_read(4, r); pop_exp(e);
        total++; if (r !== e) $display("FAIL basic_data: got %h want %h", r, e); else passed++;
        apb_read(0, r);
        total++; if (r !== 32'h0) $display("FAIL basic_read_clears: got %h want 0", r); else passed++;
        total++; if (fabint !== 1'b0) $display("FAIL basic_fabint_clear: got %b want 0", fabint); else passed++;
    endtask

    task automatic test_overrun;
        send_frame(8'h3C, 24, 6, 6, 6, 12, 1);
        repeat (8) @(negedge clk);
        send_frame(8'hC3, 24, 6, 6, 6, 12, 1);
        repeat (6) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h3) $display("FAIL overrun_status: got %h want 3", r); else passed++;
        apb_write(12, 32'h3);
        apb_read(0, r);
        total++; if (r !== 32'h0) $display("FAIL overrun_clear: got %h want 0", r); else passed++;
        apb_read(12, r);
        total++; if (r !== 32'h0) $display("FAIL clear_reads_zero: got %h want 0", r); else passed++;
        apb_read(4, r); pop_exp(e);
        total++; if (r !== e) $display("FAIL overrun_data: got %h want %h", r, e); else passed++;
    endtask

    task automatic test_bit_error;
        lvl(0, 24); lvl(1, 6); lvl(0, 20);
        hit_data = 1;
        repeat (6) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h4) $display("FAIL long_mark_error: got %h want 4", r); else passed++;
        send_frame(8'h01, 24, 6, 6, 6, 12, 1);
        repeat (6) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h5) $display("FAIL recover_status: got %h want 5", r); else passed++;
        apb_read(4, r); pop_exp(e);
        total++; if (r !== e) $display("FAIL recover_data: got %h want %h", r, e); else passed++;
        apb_write(12, 32'h4);
    endtask

    task automatic test_bad_start;
        send_frame(8'h5A, 10, 6, 6, 6, 12, 0);
        repeat (6) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h0) $display("FAIL short_start_silent: got %h want 0", r); else passed++;
        lvl(0, 24);
        for (int i = 0; i < 3; i++) begin
            lvl(1, 6); lvl(0, 12);
        end
        lvl(1, 40);
        apb_read(0, r);
        total++; if (r !== 32'h4) $display("FAIL space_timeout_error: got %h want 4", r); else passed++;
        apb_write(12, 32'h4);
    endtask

    task automatic test_boundary;
        send_frame(8'h96, 18, 3, 15, 8, 9, 1);
        repeat (6) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h1) $display("FAIL bound_low_status: got %h want 1", r); else passed++;
        apb_read(4, r); pop_exp(e);
        total++; if (r !== e) $display("FAIL bound_low_data: got %h want %h", r, e); else passed++;
        send_frame(8'h81, 30, 15, 3, 3, 15, 1);
        repeat (6) @(negedge clk);
        apb_read(4, r); pop_exp(e);
        total++; if (r !== e) $display("FAIL bound_high_data: got %h want %h", r, e); else passed++;
        send_frame(8'hFF, 31, 6, 6, 6, 12, 0);
        repeat (6) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h0) $display("FAIL start31_rejected: got %h want 0", r); else passed++;
        lvl(0, 24); lvl(1, 16); lvl(0, 6);
        hit_data = 1;
        repeat (6) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h4) $display("FAIL space16_rejected: got %h want 4", r); else passed++;
        apb_write(12, 32'h7);
    endtask

    task automatic test_enable_abort;
        lvl(0, 24);
        hit_data = 1;
        repeat (8) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h8) $display("FAIL busy_mid_frame: got %h want 8", r); else passed++;
        apb_write(8, 32'h0);
        apb_read(0, r);
        total++; if (r !== 32'h0) $display("FAIL abort_no_error: got %h want 0", r); else passed++;
        lvl(0, 12);
        hit_data = 1;
        repeat (8) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h0) $display("FAIL disabled_idle: got %h want 0", r); else passed++;
        apb_write(8, 32'h3);
    endtask

    task automatic test_reset_mid_frame;
        send_frame(8'h33, 24, 6, 6, 6, 12, 1);
        repeat (6) @(negedge clk);
        hit_data = 0;
        repeat (40) @(negedge clk);
        rst_n = 0;
        exp_q.delete();
        @(negedge clk);
        total++; if (fabint !== 1'b0) $display("FAIL rst_fabint: got %b want 0", fabint); else passed++;
        apb_read(4, r);
        total++; if (r !== 32'h0) $display("FAIL rst_prdata: got %h want 0", r); else passed++;
        rst_n = 1;
        repeat (3) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h0) $display("FAIL rst_status: got %h want 0", r); else passed++;
        apb_read(8, r);
        total++; if (r !== 32'h0) $display("FAIL rst_ctrl: got %h want 0", r); else passed++;
        apb_write(8, 32'h3);
        hit_data = 1;
        repeat (10) @(negedge clk);
        apb_read(0, r);
        total++; if (r !== 32'h0) $display("FAIL rst_no_partial: got %h want 0", r); else passed++;
        send_frame(8'h5A, 24, 6, 6, 6, 12, 1);
        repeat (6) @(negedge clk);
        apb_read(4, r); pop_exp(e);
        total++; if (r !== e) $display("FAIL rst_reenable_data: got %h want %h", r, e); else passed++;
    endtask

    task automatic test_read_collision;
        send_frame(8'hE7, 24, 6, 6, 6, 12, 1);
        @(negedge clk);
        apb_read(4, r);
        apb_read(0, r);
        total++; if (r !== 32'h1) $display("FAIL collision_valid: got %h want 1", r); else passed++;
        apb_read(4, r); pop_exp(e);
        total++; if (r !== e) $display("FAIL collision_data: got %h want %h", r, e); else passed++;
    endtask

    initial begin
        rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; hit_data = 1;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        test_reset;
        test_basic;
        test_overrun;
        test_bit_error;
        test_bad_start;
        test_boundary;
        test_enable_abort;
        test_reset_mid_frame;
        test_read_collision;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
